// File: rtl/regfile_write_arbiter_if.sv
// Bundle for the two writeback requesters and the register-file write port.
// The arbiter connects through the slave modport; the environment driving the
// requesters and observing the write port uses the master modport.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32
);
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);

    // Requester 0: in-order pipeline writeback path
    logic                               req0_done;
    logic                               req0_stall;
    logic [REGISTER_INDEXING_WIDTH-1:0] req0_register;
    logic [DATA_WIDTH-1:0]              req0_data;

    // Requester 1: long-latency unit (divider, load-miss return)
    logic                               req1_done;
    logic                               req1_stall;
    logic [REGISTER_INDEXING_WIDTH-1:0] req1_register;
    logic [DATA_WIDTH-1:0]              req1_data;

    // Registered register-file write port
    logic [REGISTER_INDEXING_WIDTH-1:0] write_register;
    logic [DATA_WIDTH-1:0]              write_data;
    logic                               write_activate;

    modport master (
        output req0_done, req0_register, req0_data,
        input  req0_stall,
        output req1_done, req1_register, req1_data,
        input  req1_stall,
        input  write_register, write_data, write_activate
    );

    modport slave (
        input  req0_done, req0_register, req0_data,
        output req0_stall,
        input  req1_done, req1_register, req1_data,
        output req1_stall,
        output write_register, write_data, write_activate
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between the
// pipeline writeback path (requester 0) and a long-latency unit (requester 1).
// One grant per cycle, winning write registered onto the port, x0 writes dropped.
// Optional feature macro WB_ARB_ROUND_ROBIN_EN: when defined, contention is
// resolved round robin; when undefined, requester 0 has priority and requester 1
// is forced through after MAX_WAIT consecutive denials.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int MAX_WAIT      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);

    // Elaboration-time guard: the starvation counter is only 4 bits wide
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("regfile_write_arbiter: MAX_WAIT must be in 1..15");
    end

    logic grant0;
    logic grant1;
    logic transfer0;
    logic transfer1;

    logic [REGISTER_INDEXING_WIDTH-1:0] write_register_q;
    logic [REGISTER_INDEXING_WIDTH-1:0] write_register_d;
    logic [DATA_WIDTH-1:0]              write_data_q;
    logic [DATA_WIDTH-1:0]              write_data_d;
    logic                               write_activate_q;
    logic                               write_activate_d;

    // A requester moves only when granted; stall is forced high throughout reset
    assign bus.req0_stall = rst || !grant0;
    assign bus.req1_stall = rst || !grant1;
    assign transfer0      = bus.req0_done && !bus.req0_stall;
    assign transfer1      = bus.req1_done && !bus.req1_stall;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Index of the most recently granted requester; the other one wins ties
    logic rr_last_q;
    logic rr_last_d;

    // Round-robin grant: an uncontended requester always wins
    always_comb begin
        grant0 = bus.req0_done && (!bus.req1_done ||  rr_last_q);
        grant1 = bus.req1_done && (!bus.req0_done || !rr_last_q);
    end

    // Remember who moved last so the next contention goes the other way
    always_comb begin
        rr_last_d = rr_last_q;
        if (transfer0) begin
            rr_last_d = 1'b0;
        end else if (transfer1) begin
            rr_last_d = 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    // Consecutive cycles requester 1 has been denied while asking
    logic [3:0] wait_count_q;
    logic [3:0] wait_count_d;
    logic       force_req1;

    assign force_req1 = (wait_count_q >= WAIT_LIMIT);

    // Fixed priority to requester 0 until requester 1 has waited long enough
    always_comb begin
        grant0 = bus.req0_done && (!bus.req1_done || !force_req1);
        grant1 = bus.req1_done && (!bus.req0_done ||  force_req1);
    end

    // Starvation counter: count denials, saturate, clear on service or idle
    always_comb begin
        wait_count_d = wait_count_q;
        if (!bus.req1_done || transfer1) begin
            wait_count_d = 4'd0;
        end else if (wait_count_q != 4'hF) begin
            wait_count_d = wait_count_q + 4'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_count_q <= 4'd0;
        end else begin
            wait_count_q <= wait_count_d;
        end
    end
`endif

    // Select the winning write; x0 is consumed but never activates the port
    always_comb begin
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        write_activate_d = 1'b0;
        if (transfer0) begin
            write_register_d = bus.req0_register;
            write_data_d     = bus.req0_data;
            write_activate_d = |bus.req0_register;
        end else if (transfer1) begin
            write_register_d = bus.req1_register;
            write_data_d     = bus.req1_data;
            write_activate_d = |bus.req1_register;
        end
    end

    // Write-port register; reset discards any in-flight write immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_register_q <= '0;
            write_data_q     <= '0;
            write_activate_q <= 1'b0;
        end else begin
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            write_activate_q <= write_activate_d;
        end
    end

    assign bus.write_register = write_register_q;
    assign bus.write_data     = write_data_q;
    assign bus.write_activate = write_activate_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter. Inputs change on the falling
// edge; stalls are sampled 1ns later, the write port 1ns after the rising edge.
module tb_regfile_write_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile_write_arbiter_if #(.DATA_WIDTH(32), .NUM_REGISTERS(32)) bus ();

    regfile_write_arbiter #(
        .DATA_WIDTH   (32),
        .NUM_REGISTERS(32),
        .MAX_WAIT     (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive both requesters in one shot
    task automatic applyStimulus(input logic d0, input logic [4:0] r0, input logic [31:0] v0,
                                 input logic d1, input logic [4:0] r1, input logic [31:0] v1);
        bus.req0_done     = d0;
        bus.req0_register = r0;
        bus.req0_data     = v0;
        bus.req1_done     = d1;
        bus.req1_register = r1;
        bus.req1_data     = v1;
    endtask

    // Reset holds both stalls high; the first edge after release grants a writer
    task automatic test_reset();
        logic       expWin1;
        logic [4:0] expReg;
`ifdef WB_ARB_ROUND_ROBIN_EN
        expWin1 = 1'b1;
`else
        expWin1 = 1'b0;
`endif
        expReg = expWin1 ? 5'd7 : 5'd3;
        @(posedge clk); #1;
        total++; if (bus.req0_stall !== 1'b1) begin bad++; $display("[TB] FAIL reset_stall0: got %b want 1", bus.req0_stall); end
        total++; if (bus.req1_stall !== 1'b1) begin bad++; $display("[TB] FAIL reset_stall1: got %b want 1", bus.req1_stall); end
        total++; if (bus.write_activate !== 1'b0) begin bad++; $display("[TB] FAIL reset_wa: got %b want 0", bus.write_activate); end
        total++; if (bus.write_register !== 5'd0) begin bad++; $display("[TB] FAIL reset_wr: got %0d want 0", bus.write_register); end
        total++; if (bus.write_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_wd: got %h want 0", bus.write_data); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.req0_stall !== expWin1) begin bad++; $display("[TB] FAIL release_stall0: got %b want %b", bus.req0_stall, expWin1); end
        total++; if (bus.req1_stall !== !expWin1) begin bad++; $display("[TB] FAIL release_stall1: got %b want %b", bus.req1_stall, !expWin1); end
        @(posedge clk); #1;
        total++; if (bus.write_activate !== 1'b1) begin bad++; $display("[TB] FAIL release_wa: got %b want 1", bus.write_activate); end
        total++; if (bus.write_register !== expReg) begin bad++; $display("[TB] FAIL release_wr: got %0d want %0d", bus.write_register, expReg); end
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Lone requester 1 is granted, and the port holds its values once idle
    task automatic test_single();
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        total++; if (bus.req1_stall !== 1'b0) begin bad++; $display("[TB] FAIL single_stall1: got %b want 0", bus.req1_stall); end
        total++; if (bus.req0_stall !== 1'b1) begin bad++; $display("[TB] FAIL single_idle_stall0: got %b want 1", bus.req0_stall); end
        @(posedge clk); #1;
        total++; if (bus.write_register !== 5'd5) begin bad++; $display("[TB] FAIL single_wr: got %0d want 5", bus.write_register); end
        total++; if (bus.write_data !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL single_wd: got %h want deadbeef", bus.write_data); end
        total++; if (bus.write_activate !== 1'b1) begin bad++; $display("[TB] FAIL single_wa: got %b want 1", bus.write_activate); end
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        total++; if (bus.write_activate !== 1'b0) begin bad++; $display("[TB] FAIL idle_wa: got %b want 0", bus.write_activate); end
        total++; if (bus.write_register !== 5'd5) begin bad++; $display("[TB] FAIL idle_hold_wr: got %0d want 5", bus.write_register); end
        total++; if (bus.write_data !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL idle_hold_wd: got %h want deadbeef", bus.write_data); end
    endtask

    // A write to x0 is consumed but never activates the port
    task automatic test_x0();
        @(negedge clk);
        applyStimulus(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
        #1;
        total++; if (bus.req0_stall !== 1'b0) begin bad++; $display("[TB] FAIL x0_stall0: got %b want 0", bus.req0_stall); end
        @(posedge clk); #1;
        total++; if (bus.write_activate !== 1'b0) begin bad++; $display("[TB] FAIL x0_wa: got %b want 0", bus.write_activate); end
        total++; if (bus.write_data !== 32'h0000_1234) begin bad++; $display("[TB] FAIL x0_wd: got %h want 00001234", bus.write_data); end
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

`ifndef WB_ARB_ROUND_ROBIN_EN
    // Both held: requester 0 wins four cycles, requester 1 forced in the fifth, repeating
    task automatic test_starvation();
        logic       expGrant1;
        logic [4:0] expReg;
        @(negedge clk);
        applyStimulus(1'b1, 5'd10, 32'hA0A0_0010, 1'b1, 5'd11, 32'hB1B1_0011);
        for (int k = 1; k <= 10; k++) begin
            expGrant1 = ((k % 5) == 0);
            expReg    = expGrant1 ? 5'd11 : 5'd10;
            #1;
            total++; if (bus.req0_stall !== expGrant1) begin bad++; $display("[TB] FAIL starve_stall0 cycle %0d: got %b want %b", k, bus.req0_stall, expGrant1); end
            total++; if (bus.req1_stall !== !expGrant1) begin bad++; $display("[TB] FAIL starve_stall1 cycle %0d: got %b want %b", k, bus.req1_stall, !expGrant1); end
            @(posedge clk); #1;
            total++; if (bus.write_activate !== 1'b1) begin bad++; $display("[TB] FAIL starve_wa cycle %0d: got %b want 1", k, bus.write_activate); end
            total++; if (bus.write_register !== expReg) begin bad++; $display("[TB] FAIL starve_wr cycle %0d: got %0d want %0d", k, bus.write_register, expReg); end
            @(negedge clk);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask
`else
    // Both held after requester 1 went last: grants alternate 0,1,0,1,0,1
    task automatic test_round_robin();
        logic        expGrant1;
        logic [31:0] expData;
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hCCCC_0012);
        @(negedge clk);
        applyStimulus(1'b1, 5'd13, 32'hDDDD_0013, 1'b1, 5'd12, 32'hCCCC_0012);
        for (int k = 1; k <= 6; k++) begin
            expGrant1 = ((k % 2) == 0);
            expData   = expGrant1 ? 32'hCCCC_0012 : 32'hDDDD_0013;
            #1;
            total++; if (bus.req1_stall !== !expGrant1) begin bad++; $display("[TB] FAIL rr_stall1 cycle %0d: got %b want %b", k, bus.req1_stall, !expGrant1); end
            @(posedge clk); #1;
            total++; if (bus.write_activate !== 1'b1) begin bad++; $display("[TB] FAIL rr_wa cycle %0d: got %b want 1", k, bus.write_activate); end
            total++; if (bus.write_data !== expData) begin bad++; $display("[TB] FAIL rr_wd cycle %0d: got %h want %h", k, bus.write_data, expData); end
            @(negedge clk);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask
`endif

    // Same register written by requester 0 then requester 1: the later value lands last
    task automatic test_back_to_back();
        @(negedge clk);
        applyStimulus(1'b1, 5'd7, 32'h1111_1111, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        total++; if (bus.write_data !== 32'h1111_1111) begin bad++; $display("[TB] FAIL b2b_first_wd: got %h want 11111111", bus.write_data); end
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h2222_2222);
        @(posedge clk); #1;
        total++; if (bus.write_activate !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_wa: got %b want 1", bus.write_activate); end
        total++; if (bus.write_register !== 5'd7) begin bad++; $display("[TB] FAIL b2b_second_wr: got %0d want 7", bus.write_register); end
        total++; if (bus.write_data !== 32'h2222_2222) begin bad++; $display("[TB] FAIL b2b_second_wd: got %h want 22222222", bus.write_data); end
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Reset asserted between edges kills the in-flight write at once
    task automatic test_async_reset();
        @(negedge clk);
        applyStimulus(1'b1, 5'd9, 32'h9999_0009, 1'b1, 5'd4, 32'h4444_0004);
        @(posedge clk); #1;
        total++; if (bus.write_activate !== 1'b1) begin bad++; $display("[TB] FAIL areset_pre_wa: got %b want 1", bus.write_activate); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.write_activate !== 1'b0) begin bad++; $display("[TB] FAIL areset_wa: got %b want 0", bus.write_activate); end
        total++; if (bus.write_register !== 5'd0) begin bad++; $display("[TB] FAIL areset_wr: got %0d want 0", bus.write_register); end
        total++; if (bus.req0_stall !== 1'b1) begin bad++; $display("[TB] FAIL areset_stall0: got %b want 1", bus.req0_stall); end
        total++; if (bus.req1_stall !== 1'b1) begin bad++; $display("[TB] FAIL areset_stall1: got %b want 1", bus.req1_stall); end
        @(posedge clk); #1;
        total++; if (bus.write_activate !== 1'b0) begin bad++; $display("[TB] FAIL areset_hold_wa: got %b want 0", bus.write_activate); end
        @(negedge clk);
        applyStimulus(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        #1;
        total++; if (bus.req0_stall !== 1'b0) begin bad++; $display("[TB] FAIL areset_release_stall0: got %b want 0", bus.req0_stall); end
        @(posedge clk); #1;
        total++; if (bus.write_activate !== 1'b1) begin bad++; $display("[TB] FAIL areset_release_wa: got %b want 1", bus.write_activate); end
        total++; if (bus.write_data !== 32'h9999_0009) begin bad++; $display("[TB] FAIL areset_release_wd: got %h want 99990009", bus.write_data); end
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Sequence all scenarios, then print the summary
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd7, 32'h7777_0007);
        test_reset();
        test_single();
        test_x0();
`ifndef WB_ARB_ROUND_ROBIN_EN
        test_starvation();
`else
        test_round_robin();
`endif
        test_back_to_back();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
